intt_butterfly_pipe: RTL

Pipelined Gentleman-Sande inverse-NTT butterfly for CRYSTALS-Kyber, the inverse-direction counterpart of the combinational Cooley-Tukey `ntt_butterfly`. It computes `even_out = (even + odd) mod q` and `odd_out = zeta·(odd − even) mod q` with q = 3329. It sits between the polynomial RAM read port and the write-back path of the INTT controller. A valid/ready handshake on both sides lets the controller stall freely, and a tag travels alongside the data so the controller can recover the write-back addresses.

---
 rtl/intt_butterfly_pipe_if.sv | 26 ++
 rtl/intt_butterfly_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/intt_butterfly_pipe_if.sv
// Valid/ready bus for the inverse-NTT butterfly pipeline.
// The master drives operands and accepts results; the slave is the butterfly.
interface intt_butterfly_pipe_if #(parameter int TAG_WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [11:0]          even;
  logic [11:0]          odd;
  logic [11:0]          zeta;
  logic                 in_scale;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [11:0]          even_out;
  logic [11:0]          odd_out;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, even, odd, zeta, in_scale, in_tag, out_ready,
    input  in_ready, out_valid, even_out, odd_out, out_tag
  );

  modport slave (
    input  in_valid, even, odd, zeta, in_scale, in_tag, out_ready,
    output in_ready, out_valid, even_out, odd_out, out_tag
  );
endinterface

// File: rtl/intt_butterfly_pipe.sv
// Pipelined Gentleman-Sande inverse-NTT butterfly for Kyber (q = 3329).
// Define INTT_SCALE_EN to add a fourth stage applying the final n^-1 = 3303 scaling.
module intt_butterfly_pipe #(
  parameter int TAG_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  intt_butterfly_pipe_if.slave bus
);

  localparam logic [11:0] Q         = 12'd3329;
  localparam logic [11:0] N_INV     = 12'd3303;
  // floor(2^32 / 3329); quotient estimate is at most one short for 24-bit inputs
  localparam logic [20:0] BARRETT_M = 21'd1290167;
`ifdef INTT_SCALE_EN
  localparam int SW = TAG_WIDTH + 1;
`else
  localparam int SW = TAG_WIDTH;
`endif

  function automatic logic [11:0] mod_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) begin
      s = s - {1'b0, Q};
    end else begin
      s = s;
    end
    return s[11:0];
  endfunction

  function automatic logic [11:0] mod_sub(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) begin
      d = d + {1'b0, Q};
    end else begin
      d = d;
    end
    return d[11:0];
  endfunction

  function automatic logic [11:0] barrett_reduce(input logic [23:0] x);
    logic [44:0] p;
    logic [12:0] qe;
    logic [23:0] r;
    p  = {21'd0, x} * {24'd0, BARRETT_M};
    qe = p[44:32];
    r  = x - ({11'd0, qe} * {12'd0, Q});
    if (r >= {12'd0, Q}) begin
      r = r - {12'd0, Q};
    end else begin
      r = r;
    end
    if (r >= {12'd0, Q}) begin
      r = r - {12'd0, Q};
    end else begin
      r = r;
    end
    return r[11:0];
  endfunction

  logic          v1_r, v2_r, v3_r;
  logic          adv1_s, adv2_s, adv3_s;
  logic [11:0]   sum1_r, diff1_r, zeta1_r;
  logic [11:0]   sum2_r;
  logic [23:0]   prod2_r;
  logic [11:0]   sum3_r, t3_r;
  logic [SW-1:0] side_s, side1_r, side2_r, side3_r;

`ifdef INTT_SCALE_EN
  logic          v4_r, adv4_s;
  logic [11:0]   even4_r, odd4_r;
  logic [TAG_WIDTH-1:0] tag4_r;

  assign side_s = {bus.in_scale, bus.in_tag};
`else
  assign side_s = bus.in_tag;
`endif

  // Ready chain: a stage moves when it is empty or its successor moves.
  always_comb begin
`ifdef INTT_SCALE_EN
    adv4_s = !v4_r || bus.out_ready;
    adv3_s = !v3_r || adv4_s;
`else
    adv3_s = !v3_r || bus.out_ready;
`endif
    adv2_s = !v2_r || adv3_s;
    adv1_s = !v1_r || adv2_s;
  end

  assign bus.in_ready = adv1_s;

  // S1: modular add and subtract, carry twiddle and sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      sum1_r  <= 12'd0;
      diff1_r <= 12'd0;
      zeta1_r <= 12'd0;
      side1_r <= '0;
    end else if (adv1_s) begin
      v1_r    <= bus.in_valid;
      sum1_r  <= mod_add(bus.even, bus.odd);
      diff1_r <= mod_sub(bus.odd, bus.even);
      zeta1_r <= bus.zeta;
      side1_r <= side_s;
    end
  end

  // S2: full-width twiddle product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      sum2_r  <= 12'd0;
      prod2_r <= 24'd0;
      side2_r <= '0;
    end else if (adv2_s) begin
      v2_r    <= v1_r;
      sum2_r  <= sum1_r;
      prod2_r <= {12'd0, zeta1_r} * {12'd0, diff1_r};
      side2_r <= side1_r;
    end
  end

  // S3: Barrett reduction of the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r    <= 1'b0;
      sum3_r  <= 12'd0;
      t3_r    <= 12'd0;
      side3_r <= '0;
    end else if (adv3_s) begin
      v3_r    <= v2_r;
      sum3_r  <= sum2_r;
      t3_r    <= barrett_reduce(prod2_r);
      side3_r <= side2_r;
    end
  end

`ifdef INTT_SCALE_EN
  // S4: optional multiply of both results by n^-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4_r    <= 1'b0;
      even4_r <= 12'd0;
      odd4_r  <= 12'd0;
      tag4_r  <= '0;
    end else if (adv4_s) begin
      v4_r    <= v3_r;
      even4_r <= side3_r[SW-1] ? barrett_reduce({12'd0, sum3_r} * {12'd0, N_INV}) : sum3_r;
      odd4_r  <= side3_r[SW-1] ? barrett_reduce({12'd0, t3_r} * {12'd0, N_INV}) : t3_r;
      tag4_r  <= side3_r[TAG_WIDTH-1:0];
    end
  end

  assign bus.out_valid = v4_r;
  assign bus.even_out  = even4_r;
  assign bus.odd_out   = odd4_r;
  assign bus.out_tag   = tag4_r;
`else
  assign bus.out_valid = v3_r;
  assign bus.even_out  = sum3_r;
  assign bus.odd_out   = t3_r;
  assign bus.out_tag   = side3_r;
`endif

endmodule
